// File: rtl/rv_mc_pkg.sv
// rtl/rv_mc_pkg.sv - shared types and constants for the RV32I multicycle control unit
package rv_mc_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH = 4'd0;
   localparam state_t S_FWAIT = 4'd1;
   localparam state_t S_INC   = 4'd2;
   localparam state_t S_DEC   = 4'd3;
   localparam state_t S_RB    = 4'd4;
   localparam state_t S_IB    = 4'd5;
   localparam state_t S_EXE   = 4'd6;
   localparam state_t S_ADDR  = 4'd7;
   localparam state_t S_SDATA = 4'd8;
   localparam state_t S_MWAIT = 4'd9;
   localparam state_t S_TRAP  = 4'd10;

   typedef enum logic [1:0] {
      RF_X0  = 2'b00,
      RF_RD  = 2'b01,
      RF_RS1 = 2'b10,
      RF_RS2 = 2'b11
   } rf_sel_e;

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   // ALU codes are resized to ALU_FW at the use site; -1 becomes all ones
   localparam int ALU_ADD  = 0;
   localparam int ALU_INC4 = -1;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_TIMEOUT = 2'b10;

   typedef struct packed {
      logic    pc_bus_en;
      logic    alu_bus_en;
      logic    imm_bus_en;
      logic    rf_bus_en;
      logic    rd_bus_en;
      logic    pc_en;
      logic    a_en;
      logic    b_en;
      logic    ir_en;
      logic    mar_en;
      logic    mdr_en;
      logic    rf_ren;
      logic    rf_wen;
      rf_sel_e rf_addr_sel;
      logic    mem_req;
      logic    mem_we;
   } ctrl_t;

endpackage

// File: rtl/rv_mc_wait_timer.sv
// rtl/rv_mc_wait_timer.sv - memory wait-cycle counter with timeout detect
module rv_mc_wait_timer
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int W = $clog2(MEM_TIMEOUT + 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   // Expires on the wait cycle that would bring the count to the limit
   assign o_expired = i_inc && (r_cnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/rv_mc_ctrl.sv
// rtl/rv_mc_ctrl.sv - Moore multicycle control unit for the shared-bus RV32I datapath
module rv_mc_ctrl
   import rv_mc_pkg::*;
#(
   parameter int ALU_FW      = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [6:0]        i_opcode,
   input  logic [2:0]        i_funct3,
   input  logic              i_funct7b5,
   input  logic              i_mem_ready,
   output logic              o_pc_bus_en,
   output logic              o_alu_bus_en,
   output logic              o_imm_bus_en,
   output logic              o_rf_bus_en,
   output logic              o_rd_bus_en,
   output logic              o_pc_en,
   output logic              o_a_en,
   output logic              o_b_en,
   output logic              o_ir_en,
   output logic              o_mar_en,
   output logic              o_mdr_en,
   output logic              o_rf_ren,
   output logic              o_rf_wen,
   output logic [1:0]        o_rf_addr_sel,
   output logic [ALU_FW-1:0] o_alu_func,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic              o_trap,
   output logic [1:0]        o_trap_cause,
   output logic [CNT_W-1:0]  o_instret
);

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_cause;
   logic [CNT_W-1:0]  r_instret;
   ctrl_t             w_ctl;
   ctrl_t             w_out;
   logic [ALU_FW-1:0] w_alu;
   logic              w_waiting;
   logic              w_expired;
   logic              w_retire;
   logic              w_is_r;
   logic              w_is_imm;
   logic              w_is_ld;
   logic              w_is_st;

   assign w_is_r    = (i_opcode == OP_REG);
   assign w_is_imm  = (i_opcode == OP_IMM);
   assign w_is_ld   = (i_opcode == OP_LOAD);
   assign w_is_st   = (i_opcode == OP_STORE);
   assign w_waiting = (r_state == S_FWAIT) || (r_state == S_MWAIT);
   assign w_retire  = (r_state == S_EXE) || ((r_state == S_MWAIT) && i_mem_ready);

   rv_mc_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (!w_waiting),
      .i_inc    (w_waiting && !i_mem_ready),
      .o_expired(w_expired)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: w_next = S_FWAIT;
         S_FWAIT: begin
            if (i_mem_ready)    w_next = S_INC;
            else if (w_expired) w_next = S_TRAP;
         end
         S_INC: w_next = S_DEC;
         S_DEC: begin
            if (w_is_r)                                 w_next = S_RB;
            else if (w_is_imm || w_is_ld || w_is_st)    w_next = S_IB;
            else                                        w_next = S_TRAP;
         end
         S_RB:    w_next = S_EXE;
         S_IB:    w_next = w_is_imm ? S_EXE : S_ADDR;
         S_EXE:   w_next = S_FETCH;
         S_ADDR:  w_next = w_is_st ? S_SDATA : S_MWAIT;
         S_SDATA: w_next = S_MWAIT;
         S_MWAIT: begin
            if (i_mem_ready)    w_next = S_FETCH;
            else if (w_expired) w_next = S_TRAP;
         end
         default: w_next = S_TRAP;
      endcase
   end

   always_comb begin
      w_ctl = '0;
      w_alu = '0;
      case (r_state)
         S_FETCH: begin
            w_ctl.pc_bus_en = 1'b1;
            w_ctl.mar_en    = 1'b1;
            w_ctl.a_en      = 1'b1;
         end
         S_FWAIT: begin
            w_ctl.mem_req   = 1'b1;
            w_ctl.rd_bus_en = i_mem_ready;
            w_ctl.ir_en     = i_mem_ready;
         end
         S_INC: begin
            w_alu            = ALU_FW'(ALU_INC4);
            w_ctl.alu_bus_en = 1'b1;
            w_ctl.pc_en      = 1'b1;
         end
         S_DEC: begin
            w_ctl.rf_ren      = 1'b1;
            w_ctl.rf_addr_sel = RF_RS1;
            w_ctl.rf_bus_en   = 1'b1;
            w_ctl.a_en        = 1'b1;
         end
         S_RB: begin
            w_ctl.rf_ren      = 1'b1;
            w_ctl.rf_addr_sel = RF_RS2;
            w_ctl.rf_bus_en   = 1'b1;
            w_ctl.b_en        = 1'b1;
         end
         S_IB: begin
            w_ctl.imm_bus_en = 1'b1;
            w_ctl.b_en       = 1'b1;
         end
         S_EXE: begin
            // funct7[5] only selects SUB/SRA: R-type ops, or shift-right immediates
            w_alu[3:0]        = {i_funct7b5 & (w_is_r | (i_funct3 == 3'b101)), i_funct3};
            w_ctl.alu_bus_en  = 1'b1;
            w_ctl.rf_wen      = 1'b1;
            w_ctl.rf_addr_sel = RF_RD;
         end
         S_ADDR: begin
            w_alu            = ALU_FW'(ALU_ADD);
            w_ctl.alu_bus_en = 1'b1;
            w_ctl.mar_en     = 1'b1;
         end
         S_SDATA: begin
            w_ctl.rf_ren      = 1'b1;
            w_ctl.rf_addr_sel = RF_RS2;
            w_ctl.rf_bus_en   = 1'b1;
            w_ctl.mdr_en      = 1'b1;
         end
         S_MWAIT: begin
            w_ctl.mem_req = 1'b1;
            w_ctl.mem_we  = w_is_st;
            if (i_mem_ready && w_is_ld) begin
               w_ctl.rd_bus_en   = 1'b1;
               w_ctl.rf_wen      = 1'b1;
               w_ctl.rf_addr_sel = RF_RD;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_FETCH;
         r_cause   <= TC_NONE;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
            r_cause <= w_waiting ? TC_TIMEOUT : TC_ILLEGAL;
         end
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   // Reset forces every output low in the same cycle, before the state register settles
   assign w_out         = i_rst ? '0 : w_ctl;
   assign o_pc_bus_en   = w_out.pc_bus_en;
   assign o_alu_bus_en  = w_out.alu_bus_en;
   assign o_imm_bus_en  = w_out.imm_bus_en;
   assign o_rf_bus_en   = w_out.rf_bus_en;
   assign o_rd_bus_en   = w_out.rd_bus_en;
   assign o_pc_en       = w_out.pc_en;
   assign o_a_en        = w_out.a_en;
   assign o_b_en        = w_out.b_en;
   assign o_ir_en       = w_out.ir_en;
   assign o_mar_en      = w_out.mar_en;
   assign o_mdr_en      = w_out.mdr_en;
   assign o_rf_ren      = w_out.rf_ren;
   assign o_rf_wen      = w_out.rf_wen;
   assign o_rf_addr_sel = w_out.rf_addr_sel;
   assign o_mem_req     = w_out.mem_req;
   assign o_mem_we      = w_out.mem_we;
   assign o_alu_func    = i_rst ? '0 : w_alu;
   assign o_trap        = !i_rst && (r_state == S_TRAP);
   assign o_trap_cause  = i_rst ? TC_NONE : r_cause;
   assign o_instret     = i_rst ? '0 : r_instret;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb/tb_rv_mc_ctrl.sv - randomized self-checking bench for rv_mc_ctrl
module tb_rv_mc_ctrl;

   localparam int          MT      = 4;
   localparam int          CW      = 4;
   localparam logic [6:0]  OP_R    = 7'b0110011;
   localparam logic [6:0]  OP_I    = 7'b0010011;
   localparam logic [6:0]  OP_L    = 7'b0000011;
   localparam logic [6:0]  OP_S    = 7'b0100011;
   localparam logic [14:0] FETCH_V = 15'b100000100100000;

   logic          i_clk       = 1'b0;
   logic          i_rst       = 1'b1;
   logic [6:0]    i_opcode    = '0;
   logic [2:0]    i_funct3    = '0;
   logic          i_funct7b5  = 1'b0;
   logic          i_mem_ready = 1'b0;
   logic          o_pc_bus_en, o_alu_bus_en, o_imm_bus_en, o_rf_bus_en, o_rd_bus_en;
   logic          o_pc_en, o_a_en, o_b_en, o_ir_en, o_mar_en, o_mdr_en;
   logic          o_rf_ren, o_rf_wen, o_mem_req, o_mem_we, o_trap;
   logic [1:0]    o_rf_addr_sel, o_trap_cause;
   logic [3:0]    o_alu_func;
   logic [CW-1:0] o_instret;
   logic [14:0]   en_vec;

   int n_tests     = 0;
   int n_fail      = 0;
   int exp_instret = 0;

   assign en_vec = {o_pc_bus_en, o_alu_bus_en, o_imm_bus_en, o_rf_bus_en, o_rd_bus_en,
                    o_pc_en, o_a_en, o_b_en, o_ir_en, o_mar_en, o_mdr_en,
                    o_rf_ren, o_rf_wen, o_mem_req, o_mem_we};

   rv_mc_ctrl #(.ALU_FW(4), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
      .i_funct7b5(i_funct7b5), .i_mem_ready(i_mem_ready),
      .o_pc_bus_en(o_pc_bus_en), .o_alu_bus_en(o_alu_bus_en), .o_imm_bus_en(o_imm_bus_en),
      .o_rf_bus_en(o_rf_bus_en), .o_rd_bus_en(o_rd_bus_en), .o_pc_en(o_pc_en),
      .o_a_en(o_a_en), .o_b_en(o_b_en), .o_ir_en(o_ir_en), .o_mar_en(o_mar_en),
      .o_mdr_en(o_mdr_en), .o_rf_ren(o_rf_ren), .o_rf_wen(o_rf_wen),
      .o_rf_addr_sel(o_rf_addr_sel), .o_alu_func(o_alu_func), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_trap(o_trap), .o_trap_cause(o_trap_cause), .o_instret(o_instret)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      exp_instret = 0;
   endtask

   // Runs one instruction with a memory that answers after fw (fetch) / mw (data) wait cycles,
   // then compares the observed behaviour against latency/handshake rules derived from the spec.
   task automatic run_check(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input int fw, input int mw);
      int          lat = -1, nreq = 0, nwe = 0, nwen = 0, bus_max = 0, wcnt = 0, ridx = 0, tgt, bus;
      logic        alu_seen = 1'b0, got_trap = 1'b0;
      logic [3:0]  alu_got = '0;
      logic [1:0]  got_cause = '0;
      logic [14:0] end_vec = '0;
      int          e_lat, e_nreq, e_nwe, e_nwen;
      logic        e_trap, e_has_alu, legal, is_mem, is_st;
      logic [1:0]  e_cause;
      logic [3:0]  e_alu;
      i_opcode = op; i_funct3 = f3; i_funct7b5 = f7;
      for (int c = 0; c < 64; c++) begin
         if (c > 0 && (o_pc_bus_en || o_trap)) begin
            lat = c; got_trap = o_trap; got_cause = o_trap_cause; end_vec = en_vec;
            break;
         end
         tgt = (ridx == 0) ? fw : mw;
         if (o_mem_req) begin
            if (wcnt >= tgt) begin i_mem_ready = 1'b1; wcnt = 0; ridx++; end
            else begin i_mem_ready = 1'b0; wcnt++; end
         end else begin
            i_mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         nreq += int'(o_mem_req);
         nwe  += int'(o_mem_we);
         nwen += int'(o_rf_wen);
         bus = $countones({o_pc_bus_en, o_alu_bus_en, o_imm_bus_en, o_rf_bus_en, o_rd_bus_en});
         if (bus > bus_max) bus_max = bus;
         if (o_rf_wen && o_alu_bus_en) begin alu_seen = 1'b1; alu_got = o_alu_func; end
         @(negedge i_clk);
      end

      legal  = (op == OP_R) || (op == OP_I) || (op == OP_L) || (op == OP_S);
      is_mem = (op == OP_L) || (op == OP_S);
      is_st  = (op == OP_S);
      e_nwe = 0; e_nwen = 0; e_trap = 1'b0; e_cause = 2'b00; e_has_alu = 1'b0;
      e_alu = {f7 & ((op == OP_R) || (f3 == 3'b101)), f3};
      if (fw >= MT) begin
         e_lat = 1 + MT; e_nreq = MT; e_trap = 1'b1; e_cause = 2'b10;
      end else if (!legal) begin
         e_lat = 4 + fw; e_nreq = fw + 1; e_trap = 1'b1; e_cause = 2'b01;
      end else if (!is_mem) begin
         e_lat = 6 + fw; e_nreq = fw + 1; e_nwen = 1; e_has_alu = 1'b1;
      end else if (mw >= MT) begin
         e_lat = 6 + fw + int'(is_st) + MT; e_nreq = fw + 1 + MT;
         e_nwe = is_st ? MT : 0; e_trap = 1'b1; e_cause = 2'b10;
      end else begin
         e_lat = 7 + fw + int'(is_st) + mw; e_nreq = fw + mw + 2;
         e_nwe = is_st ? mw + 1 : 0; e_nwen = is_st ? 0 : 1;
      end
      if (!e_trap) exp_instret = (exp_instret + 1) % (1 << CW);

      n_tests++;
      if (lat !== e_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, e_lat); end
      n_tests++;
      if ({got_trap, got_cause} !== {e_trap, e_cause}) begin
         n_fail++; $display("FAIL %s trap/cause: got %b/%b want %b/%b", name, got_trap, got_cause, e_trap, e_cause);
      end
      n_tests++;
      if (nreq !== e_nreq) begin n_fail++; $display("FAIL %s mem_req cycles: got %0d want %0d", name, nreq, e_nreq); end
      n_tests++;
      if (nwe !== e_nwe) begin n_fail++; $display("FAIL %s mem_we cycles: got %0d want %0d", name, nwe, e_nwe); end
      n_tests++;
      if (nwen !== e_nwen) begin n_fail++; $display("FAIL %s rf_wen pulses: got %0d want %0d", name, nwen, e_nwen); end
      n_tests++;
      if (bus_max > 1) begin n_fail++; $display("FAIL %s bus drivers: got %0d want <=1", name, bus_max); end
      n_tests++;
      if (end_vec !== (e_trap ? 15'b0 : FETCH_V)) begin
         n_fail++; $display("FAIL %s end enables: got %b want %b", name, end_vec, e_trap ? 15'b0 : FETCH_V);
      end
      if (e_has_alu) begin
         n_tests++;
         if ({alu_seen, alu_got} !== {1'b1, e_alu}) begin
            n_fail++; $display("FAIL %s alu_func: got %b (seen %b) want %b", name, alu_got, alu_seen, e_alu);
         end
      end
      n_tests++;
      if (o_instret !== CW'(exp_instret)) begin
         n_fail++; $display("FAIL %s instret: got %0d want %0d", name, o_instret, exp_instret);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         i_opcode = 7'($urandom); i_funct3 = 3'($urandom); i_funct7b5 = 1'($urandom); i_mem_ready = 1'b1;
         #1;
         n_tests++;
         if ({en_vec, o_alu_func, o_rf_addr_sel, o_trap, o_trap_cause, o_instret} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got en=%b alu=%b trap=%b", en_vec, o_alu_func, o_trap);
         end
         @(negedge i_clk);
      end
      i_rst = 1'b0;
      #1;
      n_tests++;
      if ({en_vec, o_alu_func, o_rf_addr_sel} !== {FETCH_V, 4'b0, 2'b0}) begin
         n_fail++; $display("FAIL first_fetch: got %b want %b", en_vec, FETCH_V);
      end
      n_tests++;
      if ({o_trap, o_trap_cause, o_instret} !== '0) begin
         n_fail++; $display("FAIL first_fetch_status: got trap=%b cause=%b instret=%0d want 0", o_trap, o_trap_cause, o_instret);
      end
   endtask

   task automatic test_alu();
      run_check("add",     OP_R, 3'b000, 1'b0, 0, 0);
      run_check("sub",     OP_R, 3'b000, 1'b1, 0, 0);
      run_check("srai",    OP_I, 3'b101, 1'b1, 0, 0);
      run_check("addi_f7", OP_I, 3'b000, 1'b1, 0, 0);
      run_check("sra",     OP_R, 3'b101, 1'b1, 1, 0);
      run_check("andi_f7", OP_I, 3'b111, 1'b1, 2, 0);
   endtask

   task automatic test_mem_wait();
      run_check("store_w3", OP_S, 3'b010, 1'b0, 0, 3);
      run_check("load_w2",  OP_L, 3'b010, 1'b0, 2, 2);
      run_check("load_w0",  OP_L, 3'b000, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [6:0] op;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0:       op = OP_R;
            1:       op = OP_I;
            2:       op = OP_L;
            default: op = OP_S;
         endcase
         run_check("random", op, 3'($urandom), 1'($urandom),
                   int'($urandom_range(0, MT - 1)), int'($urandom_range(0, MT - 1)));
      end
   endtask

   task automatic test_illegal();
      int         bad = 0;
      logic [6:0] op;
      run_check("illegal_7f", 7'h7f, 3'($urandom), 1'($urandom), 1, 0);
      for (int c = 0; c < 20; c++) begin
         i_mem_ready = 1'($urandom); i_opcode = 7'($urandom);
         #1;
         if ({en_vec, o_alu_func, o_rf_addr_sel} !== '0 || o_trap !== 1'b1 || o_trap_cause !== 2'b01) bad++;
         @(negedge i_clk);
      end
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL trap_hold: got %0d bad cycles want 0", bad); end
      do_reset();
      #1;
      n_tests++;
      if ({o_trap, o_trap_cause, en_vec} !== {3'b000, FETCH_V}) begin
         n_fail++; $display("FAIL trap_cleared: got trap=%b cause=%b en=%b", o_trap, o_trap_cause, en_vec);
      end
      do op = 7'($urandom);
      while (op == OP_R || op == OP_I || op == OP_L || op == OP_S);
      run_check("illegal_rand", op, 3'($urandom), 1'($urandom), 0, 0);
      do_reset();
   endtask

   task automatic test_timeout();
      run_check("fetch_timeout", OP_R, 3'b000, 1'b0, MT, 0);
      do_reset();
      run_check("fetch_ready_last", OP_R, 3'b000, 1'b0, MT - 1, 0);
      run_check("load_timeout", OP_L, 3'b010, 1'b0, 0, MT);
      do_reset();
      run_check("store_ready_last", OP_S, 3'b010, 1'b0, 0, MT - 1);
      run_check("store_timeout", OP_S, 3'b010, 1'b0, 1, MT + 2);
      do_reset();
   endtask

   task automatic test_reset_mid_wait();
      logic wen_seen = 1'b0;
      run_check("pre_addi", OP_I, 3'b000, 1'b0, 0, 0);
      i_opcode = OP_L; i_funct3 = 3'b010; i_funct7b5 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         i_mem_ready = (c == 1);
         #1;
         if (o_rf_wen) wen_seen = 1'b1;
         @(negedge i_clk);
      end
      n_tests++;
      if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL mwait_req: got %b want 1", o_mem_req); end
      i_rst = 1'b1; i_mem_ready = 1'b1;
      #1;
      if (o_rf_wen) wen_seen = 1'b1;
      n_tests++;
      if ({en_vec, o_alu_func, o_instret} !== '0) begin
         n_fail++; $display("FAIL rst_gate: got en=%b instret=%0d want 0", en_vec, o_instret);
      end
      @(negedge i_clk);
      i_rst = 1'b0; exp_instret = 0;
      #1;
      if (o_rf_wen) wen_seen = 1'b1;
      n_tests++;
      if (en_vec !== FETCH_V) begin n_fail++; $display("FAIL fetch_after_rst: got %b want %b", en_vec, FETCH_V); end
      n_tests++;
      if (o_instret !== '0) begin n_fail++; $display("FAIL instret_after_rst: got %0d want 0", o_instret); end
      n_tests++;
      if (wen_seen !== 1'b0) begin n_fail++; $display("FAIL abandoned_load_wen: got %b want 0", wen_seen); end
      run_check("post_rst_load", OP_L, 3'b010, 1'b0, 0, 1);
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_alu();
      test_mem_wait();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Parametrised multicycle control unit for the shared-bus RV32I datapath. It sequences fetch, PC increment, decode, execute and memory access. Every datapath bus driver, register enable, register-file port and memory request is driven from one Moore state machine. Compared with the first-generation unit, it adds a memory ready handshake with timeout, illegal-opcode trapping, a configurable ALU-function width and a retired-instruction counter.

## Interface
Parameters:
- ALU_FW, 4, ALU function code width; low 4 bits carry {funct7[5], funct3}.
- MEM_TIMEOUT, 16, max consecutive wait cycles without mem_ready before trap (≥1).
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- mem_ready  in  1  memory completes current request this cycle.
- pc_bus_en, alu_bus_en, imm_bus_en, rf_bus_en, rd_bus_en  out  1 each  bus driver enables (one-hot or none).
- pc_en, a_en, b_en, ir_en, mar_en, mdr_en  out  1 each  register load enables.
- rf_ren, rf_wen  out  1 each  register-file read/write.
- rf_addr_sel  out  2  register-file address select, encoded {x0, rd, rs1, rs2}.
- alu_func  out  ALU_FW  ALU operation.
- mem_req, mem_we  out  1 each  memory request / write qualifier.
- trap  out  1  sticky halt flag.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, FWAIT, INC, DEC, RB, IB, EXE, ADDR, SDATA, MWAIT, TRAP. All outputs are 0 unless listed for a state.
- FETCH:
  - Asserts pc_bus_en, mar_en, a_en.
  - Next state: FWAIT.
- FWAIT:
  - Asserts mem_req.
  - When mem_ready=1, also asserts rd_bus_en and ir_en, then goes to INC.
- INC:
  - Asserts alu_func=ALU_INC4 (all ones), alu_bus_en, pc_en.
  - Next state: DEC.
- DEC:
  - Asserts rf_ren, rf_addr_sel=rs1, rf_bus_en, a_en.
  - Next state by opcode:
    - 0110011 → RB
    - 0010011, 0000011, 0100011 → IB
    - any other opcode → TRAP with cause 01.
- RB:
  - Asserts rf_ren, rf_addr_sel=rs2, rf_bus_en, b_en.
  - Next state: EXE.
- IB:
  - Asserts imm_bus_en, b_en.
  - Next state: EXE for OP-IMM, ADDR for load/store.
- EXE:
  - Asserts alu_bus_en, rf_wen, rf_addr_sel=rd.
  - alu_func = zero-extended {funct7b5 & (R-type | funct3==101), funct3}.
  - Next state: FETCH.
- ADDR:
  - Asserts alu_func=ALU_ADD (0), alu_bus_en, mar_en.
  - Next state: SDATA for store, MWAIT for load.
- SDATA:
  - Asserts rf_ren, rf_addr_sel=rs2, rf_bus_en, mdr_en.
  - Next state: MWAIT.
- MWAIT:
  - Asserts mem_req; mem_we=1 for store.
  - When mem_ready=1 on a load, also asserts rd_bus_en, rf_wen, rf_addr_sel=rd.
  - Next state: FETCH.
- TRAP: all enables 0, trap=1; holds until rst.
- Wait timer:
  - Cleared on entry to FWAIT/MWAIT; increments each wait cycle with mem_ready=0.
  - On reaching MEM_TIMEOUT, next state is TRAP with cause 10.
  - mem_ready=1 in the same cycle the limit is reached wins: the transfer completes.
- instret: increments on the EXE→FETCH and MWAIT→FETCH transitions only; wraps modulo 2^CNT_W.
- mem_ready outside FWAIT/MWAIT is ignored.

## Timing
- Outputs are Moore, decoded from the registered state. The only exception is the mem_ready-qualified enables in FWAIT/MWAIT, which are combinational on mem_ready.
- Handshake:
  - mem_req stays high until the cycle mem_ready is sampled 1.
  - It deasserts the next cycle.
  - Address (MAR) and write data (MDR) are stable throughout.
- Zero-wait latency: R/I-type 6 cycles, load 7, store 8. Each wait cycle adds 1.
- Reset:
  - While rst=1, every output is 0, state←FETCH, instret←0, trap←0, trap_cause←00, wait timer←0.
  - Reset mid-wait abandons the request; mem_req is 0 in the cycle after rst is sampled.
- First instruction: FETCH is active in the first cycle after rst deasserts.

## Structure
- Package rv_mc_pkg holds:
  - the state enum
  - the rf_sel enum {x0, rd, rs1, rs2}
  - opcode constants
  - ALU_ADD and ALU_INC4
  - trap-cause codes.
- Sub-module rv_mc_wait_timer: clear/increment counter sized $clog2(MEM_TIMEOUT+1), with an expired output.

## Test plan
- Reset with add x3,x1,x2 (opcode 0110011, funct3 000), mem_ready=1 whenever requested → state sequence FETCH..EXE in 6 cycles; alu_func=0000 in EXE; instret=1.
- sub (funct7b5=1) → alu_func=1000. srai (0010011, funct3 101, funct7b5=1) → 1101. addi with funct7b5=1 → 0000.
- Store with 3 wait cycles in MWAIT → mem_req and mem_we high for 4 cycles, drop the next cycle; total latency 11 cycles; instret+1.
- Opcode 1111111 → TRAP after DEC; trap=1, cause 01; all enables 0 for 20 further cycles; rst clears trap.
- MEM_TIMEOUT=4, mem_ready never set in FWAIT → TRAP with cause 10 after 4 wait cycles. Repeat with ready on the 4th wait cycle → normal INC.
- rst asserted during MWAIT of a load → rf_wen never pulses, FETCH active the cycle after rst drops, instret=0.
